// File: rtl/rf_writeback_arb.sv
// rtl/rf_writeback_arb.sv - GPR write-port arbiter: ALU priority, load FIFO with cancellation, x0 suppression.
// Optional bypass ports to the GPR read side are built when RF_WB_FWD_EN is defined.
module rf_writeback_arb #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  output logic          rf_write,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          wb_busy
`ifdef RF_WB_FWD_EN
  ,
  input  logic [AW-1:0] fwd_addr1,
  input  logic [AW-1:0] fwd_addr2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    q_rd   [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic          ld_acc;
  logic          ld_live;
  logic          alu_iss;
  logic          fifo_empty;
  logic          iss;
  logic [AW-1:0] iss_rd;
  logic [DW-1:0] iss_data;
  logic          pop;
  logic          push;

  assign ld_ready   = (count < CW'(DEPTH));
  assign ld_acc     = ld_valid && ld_ready;
  assign ld_live    = ld_acc && (ld_rd != '0);
  assign alu_iss    = alu_valid && (alu_rd != '0);
  assign fifo_empty = (count == '0);
  assign wb_busy    = !fifo_empty || rf_write;

  // An ALU issue is younger than any load seen so far, so a same-cycle load to
  // the same register is dead and never enters the queue.
  always_comb begin
    iss      = 1'b0;
    iss_rd   = alu_rd;
    iss_data = alu_data;
    pop      = 1'b0;
    push     = 1'b0;
    if (alu_iss) begin
      iss  = 1'b1;
      push = ld_live && (ld_rd != alu_rd);
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      iss      = q_vld[head];
      iss_rd   = q_rd[head];
      iss_data = q_data[head];
      push     = ld_live;
    end else if (ld_live) begin
      iss      = 1'b1;
      iss_rd   = ld_rd;
      iss_data = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stale entries outside the live window may also get cleared; a push always
  // re-arms its slot, so that is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_iss && (q_rd[i] == alu_rd)) q_vld[i] <= 1'b0;
      end
      if (push) q_vld[tail] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= ld_rd;
      q_data[tail] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_write <= iss;
      if (iss) begin
        rf_waddr <= iss_rd;
        rf_wdata <= iss_data;
      end
    end
  end

`ifdef RF_WB_FWD_EN
  always_comb begin
    fwd_hit1  = rf_write && (rf_waddr == fwd_addr1) && (fwd_addr1 != '0);
    fwd_hit2  = rf_write && (rf_waddr == fwd_addr2) && (fwd_addr2 != '0);
    fwd_data1 = fwd_hit1 ? rf_wdata : '0;
    fwd_data2 = fwd_hit2 ? rf_wdata : '0;
  end
`endif

endmodule
